// File: rtl/shift_reg_piso.sv
// Parallel-in serial-out shift register with a one-word holding buffer so
// consecutive words stream out with no idle cycles between them.
module shift_reg_piso #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sdo,
    output logic             sdo_valid,
    output logic             sdo_first,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [WIDTH-1:0]   buf_q, buf_d;
    logic               full_q, full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sdo_q, sdo_d;
    logic               sdo_valid_q, sdo_valid_d;
    logic               sdo_first_q, sdo_first_d;

    logic               accept;
    logic               do_load;
    logic [WIDTH-1:0]   load_word;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        buf_d       = buf_q;
        full_d      = full_q;
        cnt_d       = cnt_q;
        sdo_d       = sdo_q;
        sdo_valid_d = sdo_valid_q;
        sdo_first_d = sdo_first_q;
        do_load     = 1'b0;
        load_word   = din;
        accept      = din_valid & ~full_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    do_load = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    if (MSB_FIRST) begin
                        sdo_d   = shreg_q[WIDTH-2];
                        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    end else begin
                        sdo_d   = shreg_q[1];
                        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                    end
                    cnt_d       = cnt_q + CNT_W'(1);
                    sdo_first_d = 1'b0;
                    if (accept) begin
                        buf_d  = din;
                        full_d = 1'b1;
                    end
                end else if (full_q) begin
                    // Buffered word has priority over a fresh one on the last-bit edge
                    do_load   = 1'b1;
                    load_word = buf_q;
                    full_d    = 1'b0;
                end else if (accept) begin
                    do_load = 1'b1;
                end else begin
                    state_d     = IDLE;
                    shreg_d     = '0;
                    cnt_d       = '0;
                    sdo_d       = 1'b0;
                    sdo_valid_d = 1'b0;
                    sdo_first_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (do_load) begin
            shreg_d     = load_word;
            sdo_d       = MSB_FIRST ? load_word[WIDTH-1] : load_word[0];
            cnt_d       = '0;
            sdo_valid_d = 1'b1;
            sdo_first_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            buf_q       <= '0;
            full_q      <= 1'b0;
            cnt_q       <= '0;
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            sdo_first_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            buf_q       <= buf_d;
            full_q      <= full_d;
            cnt_q       <= cnt_d;
            sdo_q       <= sdo_d;
            sdo_valid_q <= sdo_valid_d;
            sdo_first_q <= sdo_first_d;
        end
    end

    assign din_ready = ~full_q;
    assign sdo       = sdo_q;
    assign sdo_valid = sdo_valid_q;
    assign sdo_first = sdo_first_q;
    assign busy      = (state_q == SHIFT) | full_q;

endmodule

// File: tb/tb_shift_reg_piso.sv
// Drives an MSB-first and an LSB-first instance with the same stimulus and
// checks both against a word-queue model of the serial stream.
module tb_shift_reg_piso;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic ready_m, sdo_m, valid_m, first_m, busy_m;
    logic ready_l, sdo_l, valid_l, first_l, busy_l;

    int vectors = 0;
    int miscompares = 0;

    // Model: word currently on the wire, bit position, bits left, waiting words
    logic [7:0] m_cur = 8'h00;
    int         m_pos = 0;
    int         m_rem = 0;
    logic [7:0] m_wait[$];
    logic       last_acc = 1'b0;

    shift_reg_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(ready_m), .sdo(sdo_m), .sdo_valid(valid_m),
        .sdo_first(first_m), .busy(busy_m)
    );

    shift_reg_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(ready_l), .sdo(sdo_l), .sdo_valid(valid_l),
        .sdo_first(first_l), .busy(busy_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur = 8'h00;
        m_pos = 0;
        m_rem = 0;
        m_wait.delete();
    endtask

    task automatic model_start(input logic [7:0] w);
        m_cur = w;
        m_pos = 0;
        m_rem = 8;
    endtask

    task automatic model_step(input logic acc, input logic [7:0] d);
        if (m_rem > 1) begin
            m_pos++;
            m_rem--;
            if (acc) m_wait.push_back(d);
        end else if (m_wait.size() > 0) begin
            model_start(m_wait.pop_front());
        end else if (acc) begin
            model_start(d);
        end else begin
            m_rem = 0;
            m_pos = 0;
        end
    endtask

    task automatic checkOutput();
        logic exp_m, exp_l, exp_v, exp_f, exp_b, exp_r;
        exp_v = (m_rem > 0);
        exp_m = exp_v ? m_cur[7 - m_pos] : 1'b0;
        exp_l = exp_v ? m_cur[m_pos] : 1'b0;
        exp_f = exp_v && (m_pos == 0);
        exp_b = exp_v || (m_wait.size() > 0);
        exp_r = (m_wait.size() == 0);
        chk("msb.sdo", sdo_m, exp_m);
        chk("msb.sdo_valid", valid_m, exp_v);
        chk("msb.sdo_first", first_m, exp_f);
        chk("msb.busy", busy_m, exp_b);
        chk("msb.din_ready", ready_m, exp_r);
        chk("lsb.sdo", sdo_l, exp_l);
        chk("lsb.sdo_valid", valid_l, exp_v);
        chk("lsb.sdo_first", first_l, exp_f);
        chk("lsb.busy", busy_l, exp_b);
        chk("lsb.din_ready", ready_l, exp_r);
    endtask

    // One clock: drive inputs, let the edge happen, advance model, sample 1ns later
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        din       = d;
        din_valid = v;
        last_acc  = v && (m_wait.size() == 0);
        @(posedge clk);
        model_step(last_acc, d);
        #1;
        checkOutput();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, $urandom());
    endtask

    // Holds din_valid with a word until the model says it was taken, bounded
    task automatic send_held(input logic [7:0] w);
        int tries;
        tries = 0;
        do begin
            applyStimulus(1'b1, w);
            tries++;
        end while (!last_acc && tries < 40);
        vectors++;
        if (!last_acc) begin
            miscompares++;
            $error("[TB] FAIL held_accept observed=timeout expected=accept word=%h", w);
        end
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #2 checkOutput();
        #5 reset_n = 1'b1;

        // Single word, accepted on the first edge after reset release
        applyStimulus(1'b1, 8'hA5);
        idle(9);
        applyStimulus(1'b1, 8'h01);
        idle(9);

        // Back-to-back: second word three cycles later goes into the buffer
        applyStimulus(1'b1, 8'hF0);
        idle(2);
        applyStimulus(1'b1, 8'h0F);
        idle(16);

        // Late accept exactly on the last-bit edge of the running word
        applyStimulus(1'b1, 8'hFF);
        idle(7);
        applyStimulus(1'b1, 8'h81);
        idle(10);

        // Stall: valid held high across three words
        send_held(8'h5A);
        send_held(8'hC6);
        send_held(8'h39);
        idle(30);

        // Reset mid-word with a word buffered
        applyStimulus(1'b1, 8'hC3);
        applyStimulus(1'b1, 8'h3C);
        applyStimulus(1'b0, 8'h00);
        #2 reset_n = 1'b0;
        model_reset();
        #1 checkOutput();
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        idle(12);

        // Randomized traffic with varying density
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom()));
        end
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom()));
        end
        idle(25);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
